// File: rtl/ccta_result_acc.sv
// ccta_result_acc
// Collects a window of N CCTA results and reports their sum, maximum,
// minimum, the ctrl mode of the first sample and a mixed-mode flag.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready. The producer keeps valid and its data stable until the
// transfer happens. in_ready may change only with the FSM state or reset.
// out_valid stays high, and the result registers stay stable, until
// out_ready is seen high.
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-low reset
//   in_valid/q_in/ctrl_in/in_ready   sample stream from the CCTA adder
//   out_valid/out_ready              window result handshake
//   sum, max_q, min_q, mode, mixed   window result registers
//   dbg_state      current FSM state (IDLE=0, ACC=1, DONE=2)
//   avg_q          floor(sum/N), present only when CCTA_ACC_AVG_EN is defined
//
// Optional feature macro: CCTA_ACC_AVG_EN.
module ccta_result_acc #(
  parameter int DW = 5,
  parameter int N  = 8,
  localparam int CW = $clog2(N),
  localparam int SW = DW + CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] q_in,
  input  logic          ctrl_in,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] sum,
  output logic [DW-1:0] max_q,
  output logic [DW-1:0] min_q,
  output logic          mode,
  output logic          mixed,
  output logic [1:0]    dbg_state
`ifdef CCTA_ACC_AVG_EN
  ,
  output logic [DW-1:0] avg_q
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [DW-1:0] rmax_q, rmax_d;
  logic [DW-1:0] rmin_q, rmin_d;
  logic          mode_r_q, mode_r_d;
  logic          mixed_r_q, mixed_r_d;

  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] max_o_q, max_o_d;
  logic [DW-1:0] min_o_q, min_o_d;
  logic          mode_o_q, mode_o_d;
  logic          mixed_o_q, mixed_o_d;
`ifdef CCTA_ACC_AVG_EN
  logic [DW-1:0] avg_o_q, avg_o_d;
`endif

  logic          accept;
  logic [SW-1:0] nsum;
  logic [DW-1:0] nmax;
  logic [DW-1:0] nmin;
  logic          nmixed;

  // Gated with rst so the block never advertises readiness while in reset.
  assign in_ready = rst && (state_q != DONE);
  assign accept   = in_valid && in_ready;

  // Running values including the current sample; ties keep the old value.
  assign nsum   = acc_q + {{CW{1'b0}}, q_in};
  assign nmax   = (q_in > rmax_q) ? q_in : rmax_q;
  assign nmin   = (q_in < rmin_q) ? q_in : rmin_q;
  assign nmixed = mixed_r_q | (ctrl_in != mode_r_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rmax_d      = rmax_q;
    rmin_d      = rmin_q;
    mode_r_d    = mode_r_q;
    mixed_r_d   = mixed_r_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    max_o_d     = max_o_q;
    min_o_d     = min_o_q;
    mode_o_d    = mode_o_q;
    mixed_o_d   = mixed_o_q;
`ifdef CCTA_ACC_AVG_EN
    avg_o_d     = avg_o_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d     = {{CW{1'b0}}, q_in};
          rmax_d    = q_in;
          rmin_d    = q_in;
          mode_r_d  = ctrl_in;
          mixed_r_d = 1'b0;
          cnt_d     = CW'(1);
          state_d   = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (cnt_q == CW'(N - 1)) begin
            // Nth sample: publish results that already include it.
            out_valid_d = 1'b1;
            sum_d       = nsum;
            max_o_d     = nmax;
            min_o_d     = nmin;
            mode_o_d    = mode_r_q;
            mixed_o_d   = nmixed;
`ifdef CCTA_ACC_AVG_EN
            avg_o_d     = nsum[SW-1:CW];
`endif
            cnt_d       = '0;
            state_d     = DONE;
          end else begin
            acc_d     = nsum;
            rmax_d    = nmax;
            rmin_d    = nmin;
            mixed_r_d = nmixed;
            cnt_d     = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      rmax_q      <= '0;
      rmin_q      <= '0;
      mode_r_q    <= 1'b0;
      mixed_r_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      max_o_q     <= '0;
      min_o_q     <= '0;
      mode_o_q    <= 1'b0;
      mixed_o_q   <= 1'b0;
`ifdef CCTA_ACC_AVG_EN
      avg_o_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rmax_q      <= rmax_d;
      rmin_q      <= rmin_d;
      mode_r_q    <= mode_r_d;
      mixed_r_q   <= mixed_r_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      max_o_q     <= max_o_d;
      min_o_q     <= min_o_d;
      mode_o_q    <= mode_o_d;
      mixed_o_q   <= mixed_o_d;
`ifdef CCTA_ACC_AVG_EN
      avg_o_q     <= avg_o_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign max_q     = max_o_q;
  assign min_q     = min_o_q;
  assign mode      = mode_o_q;
  assign mixed     = mixed_o_q;
  assign dbg_state = state_q;
`ifdef CCTA_ACC_AVG_EN
  assign avg_q     = avg_o_q;
`endif

endmodule

// File: doc/ccta_result_acc.md
Name: ccta_result_acc

Overview:
- Downstream consumer of the CCTA adder stage.
- Takes the stream of 5-bit CCTA results (q) plus the ctrl mode tag that produced each one.
- Collects a fixed window of N results and reports sum, maximum, minimum and a mixed-mode flag.
- Results go to the next stage through a valid/ready handshake.

Parameters:
- DW, 5, width of each CCTA result sample (matches CCTA q width).
- N, 8, samples per window; power of two, 2..256.
- SW (localparam), DW+log2(N), width of the window sum; a full window of max values can never overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  q_in/ctrl_in carry a valid CCTA result.
- q_in  in  DW  CCTA result sample.
- ctrl_in  in  1  ctrl mode that produced q_in.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  window result registers are valid.
- out_ready  in  1  downstream accepts the window result.
- sum  out  SW  sum of the N samples.
- max_q  out  DW  largest sample in the window (unsigned).
- min_q  out  DW  smallest sample in the window (unsigned).
- mode  out  1  ctrl_in of the first sample in the window.
- mixed  out  1  ctrl_in changed at least once within the window.

Behaviour:
- Reset: clock and reset ports are clk and rst. Reset is synchronous and active-low: when rst==0 at a rising clk edge, the block resets.
  - State goes to IDLE; count=0.
  - in_ready=0 during reset.
  - out_valid, sum, max_q, min_q, mode, mixed all 0.
  - Reset asserted mid-window or while in DONE discards all partial/held data; there is no output for that window.
- Accept event: in_valid && in_ready at a rising edge. Samples with in_valid=0 are ignored; the count holds.
- FSM states: IDLE, ACC, DONE.
  - IDLE: in_ready=1. On accept: acc_sum=q_in, run_max=run_min=q_in, mode_r=ctrl_in, mixed_r=0, count=1, go to ACC.
  - ACC: in_ready=1. On accept:
    - acc_sum+=q_in (zero-extended to SW).
    - run_max=max(run_max,q_in); run_min=min(run_min,q_in).
    - mixed_r|=(ctrl_in!=mode_r).
    - count++.
  - ACC completion: when the accepted sample is the Nth (count==N-1 before the edge), at that same edge load the output registers with the values that include this sample, set out_valid=1, and go to DONE.
  - DONE: in_ready=0; outputs held stable while out_valid && !out_ready. On out_ready, out_valid goes to 0 on the next edge and the state returns to IDLE.
- Latency:
  - Output is valid the cycle after the Nth sample is accepted.
  - Minimum window period is N+1 cycles (one bubble for the DONE handoff).
- Arithmetic: all unsigned. The sum is exact; no saturation is needed given SW. Ties for max/min keep the existing value.
- Output registers change only on entering DONE or on reset. They keep their last values after the handoff while out_valid=0.
- Runs of in_valid gaps inside a window are allowed without limit.

Optional Feature:
- Macro: CCTA_ACC_AVG_EN.
- Defined:
  - Extra output port avg_q, out, DW wide: floor(sum/N), computed as sum>>log2(N).
  - avg_q is registered together with sum, reset to 0, and held under the same rules as sum.
- Not defined: no avg_q port and no divider logic; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0, no sample counted. After rst=1, in_ready=1.
- Basic window (N=4):
  - Stimulus: samples 5,14,7,23, ctrl=0, back-to-back.
  - Response one cycle after the 4th accept: out_valid=1, sum=49, max_q=23, min_q=5, mode=0, mixed=0.
  - With CCTA_ACC_AVG_EN: avg_q=12.
- Mixed mode + gaps (N=4):
  - Stimulus: samples 10(ctrl0), 31(ctrl1), 0(ctrl1), 2(ctrl1), with in_valid low for 3 cycles between the 2nd and 3rd samples.
  - Response: sum=43, max_q=31, min_q=0, mode=0, mixed=1; gap cycles not counted.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the window completes, with in_valid=1 held.
  - Response: outputs stable, in_ready=0, no sample consumed. On out_ready=1, out_valid drops next cycle and the next window starts from IDLE with the pending sample.
- Reset mid-window: rst=0 after 2 of 4 samples -> no out_valid. A new full window 1,1,1,1 gives sum=4, max_q=min_q=1.
- Full-scale (N=8): eight samples of 31 -> sum=248 (SW=8, no overflow), max_q=min_q=31.
